toggle_activity_monitor: RTL and testbench

- Downstream observer of the MIPS_32 core in the power-estimation flow.
- Samples one monitored core bus per enabled cycle, e.g. the ALU output or the register-file write data.
- Computes the Hamming distance to the previous sample and accumulates the toggles over a fixed window.
- Emits one activity record per window over a valid/ready handshake to the power-estimate consumer.

---
 rtl/toggle_mon_pkg.sv | 25 ++
 rtl/toggle_activity_monitor_popcount_tree.sv | 27 ++
 rtl/toggle_activity_monitor.sv | 187 ++++++++++++++++++
 tb/tb_toggle_activity_monitor.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/toggle_mon_pkg.sv
// Shared types and width helpers for the toggle activity monitor.
// Default sizes match a 32-bit bus observed over 16-sample windows.
package toggle_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BASE   = 2'd1,
        ST_RUN    = 2'd2,
        ST_REPORT = 2'd3
    } mon_state_e;

    localparam int SIG_W_DEF   = 32;
    localparam int WIN_LEN_DEF = 16;
    localparam int HD_W        = $clog2(SIG_W_DEF + 1);
    localparam int CNT_W       = $clog2(WIN_LEN_DEF + 1);

    function automatic int hd_width(input int sig_w);
        return $clog2(sig_w + 1);
    endfunction

    function automatic int cnt_width(input int win_len);
        return $clog2(win_len + 1);
    endfunction

endpackage

// File: rtl/toggle_activity_monitor_popcount_tree.sv
// popcount_tree: combinational population count built as a recursive
// balanced adder tree; count width is $clog2(W+1).
module popcount_tree #(
    parameter int W = 32
) (
    input  logic [W-1:0]           data,
    output logic [$clog2(W+1)-1:0] count
);
    localparam int OW = $clog2(W + 1);

    generate
        if (W == 1) begin : g_leaf
            assign count = data;
        end else begin : g_node
            localparam int LW = W / 2;
            localparam int HW = W - LW;
            logic [$clog2(LW+1)-1:0] count_lo_s;
            logic [$clog2(HW+1)-1:0] count_hi_s;

            popcount_tree #(.W(LW)) u_lo (.data(data[LW-1:0]), .count(count_lo_s));
            popcount_tree #(.W(HW)) u_hi (.data(data[W-1:LW]), .count(count_hi_s));

            assign count = OW'(count_lo_s) + OW'(count_hi_s);
        end
    endgenerate

endmodule

// File: rtl/toggle_activity_monitor.sv
// Toggle activity monitor: sums per-sample Hamming distance of a core bus over
// fixed windows and hands one record per window downstream. Macro PEAK_TRACK_EN adds out_peak.
module toggle_activity_monitor
    import toggle_mon_pkg::*;
#(
    parameter int SIG_W   = 32,
    parameter int WIN_LEN = 16,
    parameter int ACC_W   = 16
) (
    input  logic                         clk1,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         halt,
    input  logic                         sample_en,
    input  logic [SIG_W-1:0]             sig_in,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ACC_W-1:0]             out_toggles,
    output logic [$clog2(WIN_LEN+1)-1:0] out_samples,
    output logic [$clog2(SIG_W+1)-1:0]   out_peak,
    output logic                         out_partial,
    output logic                         overrun
);
    localparam int HDW   = hd_width(SIG_W);
    localparam int CNTW  = cnt_width(WIN_LEN);
    localparam int ACCXW = ACC_W + 1;
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(WIN_LEN - 1);

    mon_state_e       state_r;
    logic [SIG_W-1:0] prev_r;
    logic [SIG_W-1:0] diff_s;
    logic             have_base_r;
    logic             valid_r;
    logic             partial_r;
    logic             overrun_r;
    logic [ACC_W-1:0] acc_r;
    logic [ACC_W-1:0] acc_base_s;
    logic [ACC_W-1:0] acc_next_s;
    logic [ACCXW-1:0] acc_sum_s;
    logic [CNTW-1:0]  cnt_r;
    logic [CNTW-1:0]  cnt_next_s;
    logic [HDW-1:0]   hd_s;
    logic             accept_s;
    logic             count_s;
    logic             clear_s;

    assign diff_s = sig_in ^ prev_r;

    popcount_tree #(.W(SIG_W)) u_popcount (.data(diff_s), .count(hd_s));

    // Decide whether this cycle's sample joins a window; an accepted record restarts from zero.
    always_comb begin
        accept_s = valid_r & out_ready;
        if (state_r == ST_RUN) begin
            count_s = have_base_r & sample_en & ~halt;
        end else if (accept_s) begin
            count_s = sample_en & ~partial_r;
        end else begin
            count_s = 1'b0;
        end
        clear_s    = accept_s & ~count_s;
        acc_base_s = accept_s ? {ACC_W{1'b0}} : acc_r;
        cnt_next_s = (accept_s ? {CNTW{1'b0}} : cnt_r) + CNTW'(1'b1);
        acc_sum_s  = {1'b0, acc_base_s} + ACCXW'(hd_s);
        if (acc_sum_s[ACC_W]) begin
            acc_next_s = {ACC_W{1'b1}};
        end else begin
            acc_next_s = acc_sum_s[ACC_W-1:0];
        end
    end

    // Window accumulator and sample counter; frozen while a record is pending.
    always_ff @(posedge clk1) begin
        if (rst) begin
            acc_r <= {ACC_W{1'b0}};
            cnt_r <= {CNTW{1'b0}};
        end else if (count_s) begin
            acc_r <= acc_next_s;
            cnt_r <= cnt_next_s;
        end else if (clear_s) begin
            acc_r <= {ACC_W{1'b0}};
            cnt_r <= {CNTW{1'b0}};
        end
    end

`ifdef PEAK_TRACK_EN
    logic [HDW-1:0] peak_r;
    logic [HDW-1:0] peak_base_s;

    // Peak candidate restarts at zero when the pending record is taken.
    always_comb begin
        peak_base_s = accept_s ? {HDW{1'b0}} : peak_r;
    end

    // Running maximum of single-sample Hamming distance in the window.
    always_ff @(posedge clk1) begin
        if (rst) begin
            peak_r <= {HDW{1'b0}};
        end else if (count_s) begin
            peak_r <= (hd_s > peak_base_s) ? hd_s : peak_base_s;
        end else if (clear_s) begin
            peak_r <= {HDW{1'b0}};
        end
    end

    assign out_peak = peak_r;
`else
    assign out_peak = {HDW{1'b0}};
`endif

    // Control FSM: baseline capture, window run, record handshake, overrun flag.
    always_ff @(posedge clk1) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            prev_r      <= {SIG_W{1'b0}};
            have_base_r <= 1'b0;
            valid_r     <= 1'b0;
            partial_r   <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r <= ST_BASE;
                    end
                end
                ST_BASE: begin
                    if (halt) begin
                        state_r <= ST_IDLE;
                    end else if (sample_en) begin
                        prev_r      <= sig_in;
                        have_base_r <= 1'b1;
                        state_r     <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (halt) begin
                        if (cnt_r != {CNTW{1'b0}}) begin
                            state_r   <= ST_REPORT;
                            valid_r   <= 1'b1;
                            partial_r <= 1'b1;
                        end else begin
                            state_r     <= ST_IDLE;
                            have_base_r <= 1'b0;
                        end
                    end else if (sample_en) begin
                        prev_r <= sig_in;
                        if (cnt_r == CNT_LAST) begin
                            state_r   <= ST_REPORT;
                            valid_r   <= 1'b1;
                            partial_r <= 1'b0;
                        end
                    end
                end
                ST_REPORT: begin
                    if (accept_s) begin
                        valid_r   <= 1'b0;
                        partial_r <= 1'b0;
                        if (partial_r) begin
                            state_r     <= ST_IDLE;
                            have_base_r <= 1'b0;
                        end else begin
                            state_r <= ST_RUN;
                            if (sample_en) begin
                                prev_r <= sig_in;
                            end
                        end
                    end else if (sample_en) begin
                        // Keep tracking the bus so the following window stays continuous.
                        prev_r    <= sig_in;
                        overrun_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_valid   = valid_r;
    assign out_toggles = acc_r;
    assign out_samples = cnt_r;
    assign out_partial = partial_r;
    assign overrun     = overrun_r;

endmodule

// File: tb/tb_toggle_activity_monitor.sv
// Bench for toggle_activity_monitor: directed scenarios plus random traffic,
// checked against a window-queue reference model (one default and one 8-bit-accumulator instance).
module tb_toggle_activity_monitor;
    localparam int WIN_LEN = 16;

    logic clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    logic        rst, start, halt, sample_en, out_ready;
    logic [31:0] sig_in;

    logic        a_valid, a_partial, a_ovr, b_valid, b_partial, b_ovr;
    logic [15:0] a_tog;
    logic [7:0]  b_tog;
    logic [4:0]  a_samp, b_samp;
    logic [5:0]  a_peak, b_peak;

    toggle_activity_monitor #(.SIG_W(32), .WIN_LEN(WIN_LEN), .ACC_W(16)) u_dut_a (
        .clk1(clk1), .rst(rst), .start(start), .halt(halt), .sample_en(sample_en),
        .sig_in(sig_in), .out_valid(a_valid), .out_ready(out_ready), .out_toggles(a_tog),
        .out_samples(a_samp), .out_peak(a_peak), .out_partial(a_partial), .overrun(a_ovr));

    toggle_activity_monitor #(.SIG_W(32), .WIN_LEN(WIN_LEN), .ACC_W(8)) u_dut_b (
        .clk1(clk1), .rst(rst), .start(start), .halt(halt), .sample_en(sample_en),
        .sig_in(sig_in), .out_valid(b_valid), .out_ready(out_ready), .out_toggles(b_tog),
        .out_samples(b_samp), .out_peak(b_peak), .out_partial(b_partial), .overrun(b_ovr));

    wire [49:0] obs_rec  = {a_valid, b_valid, a_tog, b_tog, a_samp, b_samp, a_peak, b_peak, a_partial, b_partial};
    wire [3:0]  obs_stat = {a_valid, b_valid, a_ovr, b_ovr};

    int total = 0;
    int bad   = 0;

    // Reference model: mode, previous bus value and the Hamming distances of the open window.
    int          m_mode;
    logic [31:0] m_prev;
    int          m_win[$];
    bit          m_pending, m_partial, m_overrun;

    function automatic int hamming(input logic [31:0] x, input logic [31:0] y);
        int n = 0;
        for (int i = 0; i < 32; i++) if (x[i] != y[i]) n++;
        return n;
    endfunction

    function automatic logic [49:0] exp_rec();
        int s  = 0;
        int pk = 0;
        foreach (m_win[i]) begin
            s += m_win[i];
            if (m_win[i] > pk) pk = m_win[i];
        end
`ifndef PEAK_TRACK_EN
        pk = 0;
`endif
        return {m_pending, m_pending, 16'(s > 65535 ? 65535 : s), 8'(s > 255 ? 255 : s),
                5'(m_win.size()), 5'(m_win.size()), 6'(pk), 6'(pk), m_partial, m_partial};
    endfunction

    function automatic logic [3:0] exp_stat();
        return {m_pending, m_pending, m_overrun, m_overrun};
    endfunction

    task automatic model_step();
        bit was_partial;
        if (rst) begin
            m_mode = 0; m_prev = 32'h0; m_win.delete();
            m_pending = 0; m_partial = 0; m_overrun = 0;
        end else begin
            case (m_mode)
                0: if (start) m_mode = 1;
                1: begin
                    if (halt) m_mode = 0;
                    else if (sample_en) begin m_prev = sig_in; m_mode = 2; end
                end
                2: begin
                    if (halt) begin
                        if (m_win.size() > 0) begin m_pending = 1; m_partial = 1; m_mode = 3; end
                        else m_mode = 0;
                    end else if (sample_en) begin
                        m_win.push_back(hamming(sig_in, m_prev));
                        m_prev = sig_in;
                        if (m_win.size() == WIN_LEN) begin m_pending = 1; m_partial = 0; m_mode = 3; end
                    end
                end
                3: begin
                    if (out_ready) begin
                        was_partial = m_partial;
                        m_pending = 0; m_partial = 0; m_win.delete();
                        if (was_partial) m_mode = 0;
                        else begin
                            m_mode = 2;
                            if (sample_en) begin m_win.push_back(hamming(sig_in, m_prev)); m_prev = sig_in; end
                        end
                    end else if (sample_en) begin
                        m_prev = sig_in; m_overrun = 1;
                    end
                end
                default: m_mode = 0;
            endcase
        end
    endtask

    task automatic tick();
        @(posedge clk1);
        model_step();
        #1;
    endtask

    task automatic drive(input logic s, input logic h, input logic e, input logic r, input logic [31:0] v);
        start = s; halt = h; sample_en = e; out_ready = r; sig_in = v;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        rst = 1'b0;
        total++;
        if ({obs_rec, a_ovr, b_ovr} !== 52'h0) begin
            bad++; $display("FAIL reset_outputs: got %h expected all zero", {obs_rec, a_ovr, b_ovr});
        end
    endtask

    task automatic test_ramp();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
        for (int i = 0; i <= WIN_LEN; i++) drive(1'b0, 1'b0, 1'b1, 1'b1, 32'((64'd1 << i) - 64'd1));
        total++;
        if (obs_rec !== exp_rec()) begin
            bad++; $display("FAIL ramp_record: got %h expected %h", obs_rec, exp_rec());
        end
        total++;
        if ({a_valid, a_tog, a_samp, a_partial} !== {1'b1, 16'd16, 5'd16, 1'b0}) begin
            bad++; $display("FAIL ramp_const: got v=%0d tog=%0d n=%0d p=%0d expected 1/16/16/0", a_valid, a_tog, a_samp, a_partial);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        total++;
        if (obs_stat !== exp_stat()) begin
            bad++; $display("FAIL ramp_accept: got %b expected %b", obs_stat, exp_stat());
        end
        drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
    endtask

    task automatic test_saturate();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
        for (int i = 0; i <= WIN_LEN; i++) drive(1'b0, 1'b0, 1'b1, 1'b1, (i % 2 == 1) ? 32'hFFFF_FFFF : 32'h0);
        total++;
        if (obs_rec !== exp_rec()) begin
            bad++; $display("FAIL sat_record: got %h expected %h", obs_rec, exp_rec());
        end
        total++;
        if ({b_tog, a_tog} !== {8'd255, 16'd512}) begin
            bad++; $display("FAIL sat_const: got b=%0d a=%0d expected 255 512", b_tog, a_tog);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
    endtask

    task automatic test_backpressure();
        logic [49:0] snap;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i <= WIN_LEN; i++) drive(1'b0, 1'b0, 1'b1, 1'b0, $urandom());
        total++;
        if (obs_rec !== exp_rec()) begin
            bad++; $display("FAIL bp_record: got %h expected %h", obs_rec, exp_rec());
        end
        snap = obs_rec;
        for (int k = 0; k < 10; k++) begin
            drive(1'b0, 1'b0, (k % 3 == 1), 1'b0, $urandom());
            total++;
            if (obs_rec !== snap) begin
                bad++; $display("FAIL bp_hold: cycle %0d got %h expected %h", k, obs_rec, snap);
            end
        end
        total++;
        if ({a_ovr, b_ovr} !== 2'b11) begin
            bad++; $display("FAIL bp_overrun: got %b expected 11", {a_ovr, b_ovr});
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        for (int i = 0; i < WIN_LEN; i++) drive(1'b0, 1'b0, 1'b1, 1'b0, $urandom());
        total++;
        if (obs_rec !== exp_rec() || a_samp !== 5'd16) begin
            bad++; $display("FAIL bp_next_window: got %h expected %h", obs_rec, exp_rec());
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
    endtask

    task automatic test_halt();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 6; i++) drive(1'b0, 1'b0, 1'b1, 1'b0, $urandom());
        drive(1'b0, 1'b1, 1'b1, 1'b0, $urandom());
        total++;
        if (obs_rec !== exp_rec() || {a_valid, a_partial, a_samp} !== {1'b1, 1'b1, 5'd5}) begin
            bad++; $display("FAIL halt_partial: got %h expected %h", obs_rec, exp_rec());
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1, 1'b1, $urandom());
        total++;
        if ({a_valid, a_samp} !== {1'b0, 5'd0}) begin
            bad++; $display("FAIL halt_idle: got v=%0d n=%0d expected 0 0", a_valid, a_samp);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
        drive(1'b0, 1'b1, 1'b1, 1'b1, $urandom());
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b1, 1'b1, $urandom());
        total++;
        if ({a_valid, a_samp} !== {1'b0, 5'd0} || obs_stat !== exp_stat()) begin
            bad++; $display("FAIL halt_in_base: got v=%0d n=%0d expected 0 0", a_valid, a_samp);
        end
    endtask

    task automatic test_accept_sample();
        logic [31:0] last;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i <= WIN_LEN; i++) begin
            last = $urandom();
            drive(1'b0, 1'b0, 1'b1, 1'b0, last);
        end
        last = last ^ 32'h0000_F000;
        drive(1'b0, 1'b0, 1'b1, 1'b1, last);
        total++;
        if (a_valid !== 1'b0) begin
            bad++; $display("FAIL acc_samp_drop: got %0d expected 0", a_valid);
        end
        for (int i = 0; i < WIN_LEN - 1; i++) drive(1'b0, 1'b0, 1'b1, 1'b1, last);
        total++;
`ifdef PEAK_TRACK_EN
        if ({a_valid, a_tog, b_tog, a_samp, a_peak} !== {1'b1, 16'd4, 8'd4, 5'd16, 6'd4}) begin
`else
        if ({a_valid, a_tog, b_tog, a_samp, a_peak} !== {1'b1, 16'd4, 8'd4, 5'd16, 6'd0}) begin
`endif
            bad++; $display("FAIL acc_samp_record: got v=%0d tog=%0d n=%0d pk=%0d expected 1/4/16", a_valid, a_tog, a_samp, a_peak);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
    endtask

    task automatic test_reset_in_report();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i <= WIN_LEN; i++) drive(1'b0, 1'b0, 1'b1, 1'b0, $urandom());
        drive(1'b0, 1'b0, 1'b1, 1'b0, $urandom());
        total++;
        if (obs_stat !== 4'b1111) begin
            bad++; $display("FAIL rr_before: got %b expected 1111", obs_stat);
        end
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b1, 1'b0, $urandom());
        rst = 1'b0;
        total++;
        if (obs_stat !== 4'b0000) begin
            bad++; $display("FAIL rr_after: got %b expected 0000", obs_stat);
        end
        for (int i = 0; i <= WIN_LEN; i++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b1, $urandom());
            total++;
            if (obs_stat !== 4'b0000) begin
                bad++; $display("FAIL rr_idle: cycle %0d got %b expected 0000", i, obs_stat);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] v;
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        rst = 1'b0;
        v = 32'h0;
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            case ($urandom_range(0, 3))
                0: v = $urandom();
                1: v = v ^ (32'h1 << $urandom_range(0, 31));
                2: v = ~v;
                default: v = v;
            endcase
            drive($urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0,
                  $urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, v);
            total++;
            if (obs_stat !== exp_stat()) begin
                bad++; $display("FAIL rand_status: cycle %0d got %b expected %b", c, obs_stat, exp_stat());
            end
            if (m_pending) begin
                total++;
                if (obs_rec !== exp_rec()) begin
                    bad++; $display("FAIL rand_record: cycle %0d got %h expected %h", c, obs_rec, exp_rec());
                end
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; halt = 1'b0; sample_en = 1'b0; out_ready = 1'b0; sig_in = 32'h0;
        test_reset();
        test_ramp();
        test_saturate();
        test_backpressure();
        test_halt();
        test_accept_sample();
        test_reset_in_report();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
